// File: rtl/fnd_scan_decoder.sv
// fnd_scan_decoder
//
// Watches a multiplexed, active-low 7-segment bus and rebuilds the BCD
// digits being displayed. Each scan slot must stay stable for
// STABLE_CYCLES samples before its digit is captured; once every digit
// has been captured the whole frame is published at once.
//
// Ports:
//   clk          system clock
//   rst          asynchronous, active-high reset
//   an_n         anode selects, active-low (one low bit = valid slot)
//   seg_n        segments, active-low, bit6=a ... bit0=g
//   digits_out   decoded frame, digit i in bits [4i+3:4i]
//   err_out      per-digit "unrecognised pattern" flags of last frame
//   frame_valid  one-cycle pulse when digits_out/err_out update
//   frame_err    OR of err_out, registered with the frame
//   stale        no capture for TIMEOUT_CYCLES cycles (optional)
//
// Optional feature: define FND_SCAN_TIMEOUT_EN to build the stale-bus
// timeout. Without it, stale is tied to 0 and no counter exists.

module fnd_scan_decoder #(
    parameter int DIGITS         = 4,
    parameter int STABLE_CYCLES  = 8,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DIGITS-1:0]     an_n,
    input  logic [6:0]            seg_n,
    output logic [4*DIGITS-1:0]   digits_out,
    output logic [DIGITS-1:0]     err_out,
    output logic                  frame_valid,
    output logic                  frame_err,
    output logic                  stale
);

    localparam int CW = $clog2(STABLE_CYCLES);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] SETTLE   = 2'd1;
    localparam logic [1:0] CAPTURED = 2'd2;

    if (STABLE_CYCLES < 2 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("fnd_scan_decoder: STABLE_CYCLES must be >= 2 and TIMEOUT_CYCLES >= 1");
    end

    logic [DIGITS-1:0]   a_q, a_prev;
    logic [6:0]          s_q, s_prev;
    logic [1:0]          state;
    logic [CW-1:0]       count;
    logic [DIGITS-1:0]   sel;
    logic                one_hot;
    logic                same;
    logic                capture;
    logic [4:0]          dec;
    logic [DIGITS-1:0]   mask, mask_n;
    logic [4*DIGITS-1:0] work_val, work_val_n;
    logic [DIGITS-1:0]   work_err, work_err_n;
    logic                frame_done;
    logic                mask_clr;

    // Returns {err, value} for a registered segment pattern.
    function automatic logic [4:0] decode(input logic [6:0] p);
        case (p)
            7'b0000001: decode = 5'h00;
            7'b1001111: decode = 5'h01;
            7'b0010010: decode = 5'h02;
            7'b0000110: decode = 5'h03;
            7'b1001100: decode = 5'h04;
            7'b0100100: decode = 5'h05;
            7'b1100000: decode = 5'h06;
            7'b0001111: decode = 5'h07;
            7'b0000000: decode = 5'h08;
            7'b0001100: decode = 5'h09;
            7'b1111110: decode = 5'h0F;
            default:    decode = 5'h1E;
        endcase
    endfunction

    // Sample the bus once, and keep the previous sample for comparison.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q    <= '0;
            s_q    <= '0;
            a_prev <= '0;
            s_prev <= '0;
        end else begin
            a_q    <= an_n;
            s_q    <= seg_n;
            a_prev <= a_q;
            s_prev <= s_q;
        end
    end

    // A valid slot has exactly one anode driven low.
    assign sel     = ~a_q;
    assign one_hot = (sel != '0) && ((sel & (sel - {{(DIGITS-1){1'b0}}, 1'b1})) == '0);
    assign same    = (a_q == a_prev) && (s_q == s_prev);
    assign dec     = decode(s_q);

    // The count is the number of consecutive matching comparisons; the
    // capture edge is the one that would bring it to STABLE_CYCLES-1.
    assign capture = (state == SETTLE) && one_hot && same &&
                     (count == CW'(STABLE_CYCLES - 2));

    // Slot qualification FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    count <= '0;
                    if (one_hot)
                        state <= SETTLE;
                end
                SETTLE: begin
                    if (!one_hot) begin
                        state <= IDLE;
                        count <= '0;
                    end else if (!same) begin
                        count <= '0;
                    end else if (capture) begin
                        state <= CAPTURED;
                        count <= '0;
                    end else begin
                        count <= count + CW'(1);
                    end
                end
                CAPTURED: begin
                    count <= '0;
                    if (!same)
                        state <= one_hot ? SETTLE : IDLE;
                end
                default: begin
                    state <= IDLE;
                    count <= '0;
                end
            endcase
        end
    end

    // Next working frame including this edge's capture, so a capture on
    // the completing edge lands in the published frame.
    always_comb begin
        work_val_n = work_val;
        work_err_n = work_err;
        mask_n     = (mask_clr ? '0 : mask) | (capture ? sel : '0);
        for (int i = 0; i < DIGITS; i++) begin
            if (capture && sel[i]) begin
                work_val_n[4*i +: 4] = dec[3:0];
                work_err_n[i]        = dec[4];
            end
        end
    end

    assign frame_done = &mask_n;

    // Working registers, capture mask and frame publication.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            work_val    <= '0;
            work_err    <= '0;
            mask        <= '0;
            digits_out  <= '0;
            err_out     <= '0;
            frame_err   <= 1'b0;
            frame_valid <= 1'b0;
        end else begin
            work_val    <= work_val_n;
            work_err    <= work_err_n;
            frame_valid <= 1'b0;
            if (frame_done) begin
                digits_out  <= work_val_n;
                err_out     <= work_err_n;
                frame_err   <= |work_err_n;
                frame_valid <= 1'b1;
                mask        <= '0;
            end else begin
                mask <= mask_n;
            end
        end
    end

`ifdef FND_SCAN_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] idle_cnt;
    logic          stale_q;

    // Cycles since the last capture, saturating; stale drops the partial
    // frame so the next one is built only from fresh captures.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_cnt <= '0;
            stale_q  <= 1'b0;
        end else if (capture) begin
            idle_cnt <= '0;
            stale_q  <= 1'b0;
        end else if (idle_cnt != TW'(TIMEOUT_CYCLES)) begin
            idle_cnt <= idle_cnt + TW'(1);
            if (idle_cnt == TW'(TIMEOUT_CYCLES - 1))
                stale_q <= 1'b1;
        end
    end

    assign stale    = stale_q;
    assign mask_clr = stale_q;
`else
    assign stale    = 1'b0;
    assign mask_clr = 1'b0;
`endif

endmodule

// File: tb/tb_fnd_scan_decoder.sv
// tb_fnd_scan_decoder
//
// Directed bench for fnd_scan_decoder (DIGITS=4, STABLE_CYCLES=8).
// A decode table drives one frame per pattern; hand-written sequences
// cover glitches, capture latency, recapture, blank/multi-anode slots,
// asynchronous reset and (when FND_SCAN_TIMEOUT_EN is defined) the
// stale timeout.

module tb_fnd_scan_decoder;

    localparam int DIGITS = 4;

    localparam logic [6:0] SEG0 = 7'b0000001;
    localparam logic [6:0] SEG1 = 7'b1001111;
    localparam logic [6:0] SEG2 = 7'b0010010;
    localparam logic [6:0] SEG3 = 7'b0000110;
    localparam logic [6:0] SEG4 = 7'b1001100;
    localparam logic [6:0] SEG5 = 7'b0100100;
    localparam logic [6:0] SEG6 = 7'b1100000;
    localparam logic [6:0] SEG7 = 7'b0001111;
    localparam logic [6:0] SEG8 = 7'b0000000;
    localparam logic [6:0] SEG9 = 7'b0001100;
    localparam logic [6:0] DASH = 7'b1111110;
    localparam logic [6:0] OFF  = 7'b1111111;

    logic          clk;
    logic          rst;
    logic [3:0]    an_n;
    logic [6:0]    seg_n;
    logic [15:0]   digits_out;
    logic [3:0]    err_out;
    logic          frame_valid;
    logic          frame_err;
    logic          stale;

    int tests_run;
    int tests_failed;
    int fv_cnt;

    typedef struct {
        logic [6:0] seg;
        logic [3:0] val;
        logic       err;
    } dec_vec_t;

    dec_vec_t vecs [13];

    fnd_scan_decoder #(
        .DIGITS(DIGITS),
        .STABLE_CYCLES(8),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .clk(clk),
        .rst(rst),
        .an_n(an_n),
        .seg_n(seg_n),
        .digits_out(digits_out),
        .err_out(err_out),
        .frame_valid(frame_valid),
        .frame_err(frame_err),
        .stale(stale)
    );

    // 10 time-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count every cycle frame_valid is high, sampled just after the edge.
    always @(posedge clk) begin
        #1;
        if (frame_valid)
            fv_cnt++;
    end

    // Drive one slot pattern and hold it for the given number of clocks.
    task automatic applyStimulus(input logic [3:0] an, input logic [6:0] seg, input int cycles);
        an_n  = an;
        seg_n = seg;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Full scan d0..d3, each slot held for 'hold' clocks.
    task automatic scanFrame(input logic [6:0] s0, input logic [6:0] s1,
                             input logic [6:0] s2, input logic [6:0] s3, input int hold);
        applyStimulus(4'b1110, s0, hold);
        applyStimulus(4'b1101, s1, hold);
        applyStimulus(4'b1011, s2, hold);
        applyStimulus(4'b0111, s3, hold);
    endtask

    task automatic checkFrame(input string name, input int f0, input logic [15:0] dig,
                              input logic [3:0] err, input logic ferr);
        checkOutput({name, ".pulses"}, fv_cnt - f0, 1);
        checkOutput({name, ".digits"}, digits_out, dig);
        checkOutput({name, ".err"}, err_out, err);
        checkOutput({name, ".frame_err"}, frame_err, ferr);
    endtask

    initial begin
        int f0;
        int lat;
        bit found;

        tests_run    = 0;
        tests_failed = 0;
        fv_cnt       = 0;

        vecs[0]  = '{SEG0, 4'h0, 1'b0};
        vecs[1]  = '{SEG1, 4'h1, 1'b0};
        vecs[2]  = '{SEG2, 4'h2, 1'b0};
        vecs[3]  = '{SEG3, 4'h3, 1'b0};
        vecs[4]  = '{SEG4, 4'h4, 1'b0};
        vecs[5]  = '{SEG5, 4'h5, 1'b0};
        vecs[6]  = '{SEG6, 4'h6, 1'b0};
        vecs[7]  = '{SEG7, 4'h7, 1'b0};
        vecs[8]  = '{SEG8, 4'h8, 1'b0};
        vecs[9]  = '{SEG9, 4'h9, 1'b0};
        vecs[10] = '{DASH, 4'hF, 1'b0};
        vecs[11] = '{OFF,  4'hE, 1'b1};
        vecs[12] = '{7'b0110000, 4'hE, 1'b1};

        // Reset state.
        rst   = 1'b1;
        an_n  = 4'hF;
        seg_n = OFF;
        repeat (3) @(negedge clk);
        checkOutput("reset.digits", digits_out, 16'h0000);
        checkOutput("reset.err", err_out, 4'h0);
        checkOutput("reset.frame_valid", frame_valid, 1'b0);
        checkOutput("reset.frame_err", frame_err, 1'b0);
        checkOutput("reset.stale", stale, 1'b0);
        rst = 1'b0;
        applyStimulus(4'hF, OFF, 3);

        // Decode table: the pattern under test in d0, zeros elsewhere.
        for (int v = 0; v < 13; v++) begin
            f0 = fv_cnt;
            scanFrame(vecs[v].seg, SEG0, SEG0, SEG0, 12);
            checkFrame($sformatf("table%0d", v), f0, {12'h000, vecs[v].val},
                       {3'b000, vecs[v].err}, vecs[v].err);
        end

        // Nominal scan 4,3,2,1 on d0..d3.
        f0 = fv_cnt;
        scanFrame(SEG4, SEG3, SEG2, SEG1, 16);
        checkFrame("nominal", f0, 16'h1234, 4'h0, 1'b0);

        // Dash and unrecognised pattern in the middle digits.
        f0 = fv_cnt;
        scanFrame(SEG0, DASH, OFF, SEG7, 12);
        checkFrame("dash_invalid", f0, 16'h7EF0, 4'b0100, 1'b1);

        // Glitching d0 never qualifies, so the other three do not finish a frame.
        f0 = fv_cnt;
        for (int k = 0; k < 8; k++)
            applyStimulus(4'b1110, (k % 2 == 1) ? SEG5 : SEG4, 4);
        applyStimulus(4'b1101, SEG5, 12);
        applyStimulus(4'b1011, SEG6, 12);
        applyStimulus(4'b0111, SEG9, 12);
        checkOutput("glitch.no_frame", fv_cnt - f0, 0);
        checkOutput("glitch.hold_digits", digits_out, 16'h7EF0);
        applyStimulus(4'b1110, SEG4, 10);
        checkFrame("glitch.recover", f0, 16'h9654, 4'h0, 1'b0);

        // Slot held one clock short of the stability window is ignored;
        // then the capture latency from the d0 change is measured.
        f0 = fv_cnt;
        applyStimulus(4'b1110, SEG5, 7);
        applyStimulus(4'b1101, SEG1, 12);
        applyStimulus(4'b1011, SEG2, 12);
        applyStimulus(4'b0111, SEG3, 12);
        checkOutput("short_hold.no_frame", fv_cnt - f0, 0);
        an_n  = 4'b1110;
        seg_n = SEG8;
        lat   = 0;
        found = 1'b0;
        for (int c = 1; c <= 40 && !found; c++) begin
            @(negedge clk);
            if (frame_valid) begin
                lat   = c;
                found = 1'b1;
            end
        end
        checkOutput("latency", lat, 9);
        applyStimulus(4'b1110, SEG8, 4);
        checkFrame("latency.frame", f0, 16'h3218, 4'h0, 1'b0);

        // Recapturing d0 overwrites it; still exactly one frame.
        f0 = fv_cnt;
        applyStimulus(4'b1110, SEG1, 12);
        applyStimulus(4'b1101, SEG2, 12);
        applyStimulus(4'b1110, SEG7, 12);
        applyStimulus(4'b1011, SEG3, 12);
        applyStimulus(4'b0111, SEG4, 12);
        checkFrame("recapture", f0, 16'h4327, 4'h0, 1'b0);

        // Multi-anode and blank slots neither capture nor disturb the mask.
        f0 = fv_cnt;
        applyStimulus(4'b1110, SEG5, 12);
        applyStimulus(4'b1100, SEG6, 40);
        applyStimulus(4'b1111, SEG6, 40);
        checkOutput("blank.no_frame", fv_cnt - f0, 0);
        applyStimulus(4'b1101, SEG6, 12);
        applyStimulus(4'b1011, SEG7, 12);
        applyStimulus(4'b0111, SEG8, 12);
        checkFrame("blank.resume", f0, 16'h8765, 4'h0, 1'b0);

        // Asynchronous reset mid-frame clears outputs at once and drops the partial mask.
        applyStimulus(4'b1110, SEG9, 12);
        applyStimulus(4'b1101, SEG9, 12);
        #2 rst = 1'b1;
        #1;
        checkOutput("async_reset.digits", digits_out, 16'h0000);
        checkOutput("async_reset.frame_valid", frame_valid, 1'b0);
        an_n = 4'hF;
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(4'hF, OFF, 3);
        f0 = fv_cnt;
        applyStimulus(4'b1011, SEG1, 12);
        applyStimulus(4'b0111, SEG2, 12);
        checkOutput("after_reset.no_frame", fv_cnt - f0, 0);
        applyStimulus(4'b1110, SEG3, 12);
        applyStimulus(4'b1101, SEG4, 12);
        checkFrame("after_reset", f0, 16'h2143, 4'h0, 1'b0);

`ifdef FND_SCAN_TIMEOUT_EN
        // Two captures, then a long blank: stale rises and the partial frame is dropped.
        f0 = fv_cnt;
        applyStimulus(4'b1110, SEG1, 12);
        applyStimulus(4'b1101, SEG2, 12);
        applyStimulus(4'hF, OFF, 100);
        checkOutput("timeout.stale", stale, 1'b1);
        applyStimulus(4'b1011, SEG7, 12);
        checkOutput("timeout.stale_cleared", stale, 1'b0);
        applyStimulus(4'b0111, SEG8, 12);
        checkOutput("timeout.no_frame", fv_cnt - f0, 0);
        applyStimulus(4'b1110, SEG5, 12);
        applyStimulus(4'b1101, SEG6, 12);
        checkFrame("timeout.fresh", f0, 16'h8765, 4'h0, 1'b0);
        checkOutput("timeout.stale_final", stale, 1'b0);
`else
        checkOutput("stale_tied", stale, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
